// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU load/store unit (master) and the data-memory responder (slave).
interface dmem_responder_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_be;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word-aligned request at a time, WAIT_STATES extra
// cycles of latency, response held until the CPU takes it.
module dmem_responder #(
   parameter int DMEM_ADDR_WIDTH = 12,
   parameter int DMEM_DATA_WIDTH = 32,
   parameter int WAIT_STATES     = 1
) (
   input  logic           clk,
   input  logic           rst,
   dmem_responder_if.slave bus
);
   localparam int AW    = DMEM_ADDR_WIDTH;
   localparam int DW    = DMEM_DATA_WIDTH;
   localparam int NB    = DW / 8;
   localparam int WORDS = 2 ** (AW - 2);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic            p_we;
   logic [AW-1:0]   p_addr;
   logic [DW-1:0]   p_wdata;
   logic [NB-1:0]   p_be;
   logic [DW-1:0]   mem [WORDS];

   logic            commit;
   logic            misal;
   logic [AW-3:0]   widx;

   // Counter is loaded with WAIT_STATES on accept and RESP is entered on the
   // edge it is seen at zero, so rsp_valid rises WAIT_STATES+1 edges after accept.
   assign commit = (state == WAIT) && (cnt == 4'd0);
   assign misal  = (p_addr[1:0] != 2'b00);
   assign widx   = p_addr[AW-1:2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         p_we          <= 1'b0;
         p_addr        <= '0;
         p_wdata       <= '0;
         p_be          <= '0;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  p_we          <= bus.req_we;
                  p_addr        <= bus.req_addr;
                  p_wdata       <= bus.req_wdata;
                  p_be          <= bus.req_be;
                  cnt           <= 4'(WAIT_STATES);
                  bus.req_ready <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (commit) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= misal;
                  bus.rsp_rdata <= (misal || p_we) ? '0 : mem[widx];
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is deliberately not reset; a store lands on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (commit && p_we && !misal) begin
         for (int i = 0; i < NB; i++) begin
            if (p_be[i]) mem[widx][8*i +: 8] <= p_wdata[8*i +: 8];
         end
      end
   end
endmodule
